// File: rtl/adc_channel_display.sv
// Channel selector and 4-digit multiplexed 7-segment driver for BCD ADC readings.
// Channels auto-cycle on a dwell timer or step on a debounced pushbutton.
module adc_channel_display #(
  parameter int REFRESH_DIV  = 100000,
  parameter int DWELL_DIV    = 200000000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] channel0,
  input  logic [15:0] channel1,
  input  logic [15:0] channel2,
  input  logic [15:0] channel3,
  input  logic        btn_next,
  input  logic        hold,
  output logic [6:0]  sseg,
  output logic [3:0]  an,
  output logic        dp,
  output logic [3:0]  led_ch
);

  localparam int RW = $clog2(REFRESH_DIV > 1 ? REFRESH_DIV : 2);
  localparam int WW = $clog2(DWELL_DIV > 1 ? DWELL_DIV : 2);
  localparam int DW = $clog2(DEBOUNCE_CYC > 1 ? DEBOUNCE_CYC : 2);
  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [WW-1:0] DWELL_LAST = WW'(DWELL_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [6:0]    SEG_BLANK  = 7'b1111111;

  logic          btnMeta_q, btnSync_q;
  logic          dbLevel_q, dbLevel_d, dbPrev_q;
  logic [DW-1:0] dbCnt_q, dbCnt_d;
  logic [WW-1:0] dwellCnt_q, dwellCnt_d;
  logic [1:0]    chIdx_q, chIdx_d;
  logic [RW-1:0] refCnt_q, refCnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [15:0]   snapshot_q, snapshot_d;
  logic [6:0]    sseg_q, sseg_d;
  logic [3:0]    an_q, ledCh_q;

  logic        nextPulse, dwellPulse, advance, refreshTick, frameStart;
  logic [15:0] selWord;
  logic        blankThou, blankHund, blankTens;

  function automatic logic [6:0] segDecode(input logic [3:0] nib);
    case (nib)
      4'd0:    segDecode = 7'b1000000;
      4'd1:    segDecode = 7'b1111001;
      4'd2:    segDecode = 7'b0100100;
      4'd3:    segDecode = 7'b0110000;
      4'd4:    segDecode = 7'b0011001;
      4'd5:    segDecode = 7'b0010010;
      4'd6:    segDecode = 7'b0000010;
      4'd7:    segDecode = 7'b1111000;
      4'd8:    segDecode = 7'b0000000;
      4'd9:    segDecode = 7'b0010000;
      default: segDecode = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    // A level change is accepted only once the synchronized input has differed for DEBOUNCE_CYC cycles.
    dbLevel_d = dbLevel_q;
    dbCnt_d   = '0;
    if (btnSync_q != dbLevel_q) begin
      if (dbCnt_q == DEB_LAST) begin
        dbLevel_d = btnSync_q;
      end else begin
        dbCnt_d = dbCnt_q + 1'b1;
      end
    end

    nextPulse  = dbLevel_q & ~dbPrev_q;
    dwellPulse = ~hold & (dwellCnt_q == DWELL_LAST);
    advance    = nextPulse | dwellPulse;

    dwellCnt_d = dwellCnt_q;
    if (advance) begin
      dwellCnt_d = '0;
    end else if (!hold) begin
      dwellCnt_d = dwellCnt_q + 1'b1;
    end
    chIdx_d = advance ? chIdx_q + 2'd1 : chIdx_q;

    refreshTick = (refCnt_q == REF_LAST);
    refCnt_d    = refreshTick ? '0 : refCnt_q + 1'b1;
    dig_d       = refreshTick ? dig_q + 2'd1 : dig_q;
    frameStart  = refreshTick && (dig_q == 2'd3);

    case (chIdx_d)
      2'd0:    selWord = channel0;
      2'd1:    selWord = channel1;
      2'd2:    selWord = channel2;
      default: selWord = channel3;
    endcase
    snapshot_d = (advance || frameStart) ? selWord : snapshot_q;

    // Out-of-range nibbles count as non-zero so a dash is never blanked away.
    blankThou = (snapshot_q[15:12] == 4'd0);
    blankHund = blankThou && (snapshot_q[11:8] == 4'd0);
    blankTens = blankHund && (snapshot_q[7:4] == 4'd0);
    sseg_d    = SEG_BLANK;
    case (dig_q)
      2'd0: sseg_d = segDecode(snapshot_q[3:0]);
      2'd1: sseg_d = blankTens ? SEG_BLANK : segDecode(snapshot_q[7:4]);
      2'd2: sseg_d = blankHund ? SEG_BLANK : segDecode(snapshot_q[11:8]);
      2'd3: sseg_d = blankThou ? SEG_BLANK : segDecode(snapshot_q[15:12]);
      default: sseg_d = SEG_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btnMeta_q  <= 1'b0;
      btnSync_q  <= 1'b0;
      dbLevel_q  <= 1'b0;
      dbPrev_q   <= 1'b0;
      dbCnt_q    <= '0;
      dwellCnt_q <= '0;
      chIdx_q    <= 2'd0;
      refCnt_q   <= '0;
      dig_q      <= 2'd0;
      snapshot_q <= 16'h0000;
      sseg_q     <= SEG_BLANK;
      an_q       <= 4'b1111;
      ledCh_q    <= 4'b0001;
    end else begin
      btnMeta_q  <= btn_next;
      btnSync_q  <= btnMeta_q;
      dbLevel_q  <= dbLevel_d;
      dbPrev_q   <= dbLevel_q;
      dbCnt_q    <= dbCnt_d;
      dwellCnt_q <= dwellCnt_d;
      chIdx_q    <= chIdx_d;
      refCnt_q   <= refCnt_d;
      dig_q      <= dig_d;
      snapshot_q <= snapshot_d;
      sseg_q     <= sseg_d;
      an_q       <= ~(4'b0001 << dig_q);
      ledCh_q    <= 4'b0001 << chIdx_q;
    end
  end

  assign sseg   = sseg_q;
  assign an     = an_q;
  assign dp     = 1'b1;
  assign led_ch = ledCh_q;

endmodule

// File: tb/tb_adc_channel_display.sv
// Directed-vector bench for adc_channel_display using small dividers so scan,
// dwell and debounce timing can be checked cycle by cycle.
module tb_adc_channel_display;

  localparam int REFRESH_DIV  = 4;
  localparam int DWELL_DIV    = 64;
  localparam int DEBOUNCE_CYC = 8;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] channel0, channel1, channel2, channel3;
  logic        btn_next, hold;
  logic [6:0]  sseg;
  logic [3:0]  an;
  logic        dp;
  logic [3:0]  led_ch;

  int vectors = 0;
  int miscompares = 0;
  int n;

  adc_channel_display #(
    .REFRESH_DIV (REFRESH_DIV),
    .DWELL_DIV   (DWELL_DIV),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .channel0(channel0),
    .channel1(channel1),
    .channel2(channel2),
    .channel3(channel3),
    .btn_next(btn_next),
    .hold    (hold),
    .sseg    (sseg),
    .an      (an),
    .dp      (dp),
    .led_ch  (led_ch)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] c0, input logic [15:0] c1,
                               input logic [15:0] c2, input logic [15:0] c3, input logic h);
    channel0 = c0;
    channel1 = c1;
    channel2 = c2;
    channel3 = c3;
    hold     = h;
  endtask

  task automatic waitAn(input logic [3:0] target, input string tag);
    int k = 0;
    while (an !== target && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (an !== target) checkOutput({tag, " timeout"}, {28'd0, an}, {28'd0, target});
  endtask

  task automatic countToLedChange(output int cnt);
    logic [3:0] old = led_ch;
    cnt = 0;
    while (led_ch === old && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic pressBtn(input int hiCyc, input int loCyc);
    btn_next = 1'b1;
    repeat (hiCyc) @(negedge clk);
    btn_next = 1'b0;
    repeat (loCyc) @(negedge clk);
  endtask

  // Two frame starts guarantee the displayed snapshot postdates any earlier input change.
  task automatic checkDisplay(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
    logic [6:0] exp [4];
    logic [3:0] anExp;
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    waitAn(4'b0111, tag); waitAn(4'b1110, tag);
    waitAn(4'b0111, tag); waitAn(4'b1110, tag);
    for (int d = 0; d < 4; d++) begin
      if (d > 0) repeat (REFRESH_DIV) @(negedge clk);
      anExp = ~(4'b0001 << d);
      checkOutput($sformatf("%s an%0d", tag, d), {28'd0, an}, {28'd0, anExp});
      checkOutput($sformatf("%s seg%0d", tag, d), {25'd0, sseg}, {25'd0, exp[d]});
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_next = 1'b0;
    applyStimulus(16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("reset an", {28'd0, an}, 32'hF);
    checkOutput("reset sseg", {25'd0, sseg}, 32'h7F);
    checkOutput("reset dp", {31'd0, dp}, 32'h1);
    checkOutput("reset led", {28'd0, led_ch}, 32'h1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("release an", {28'd0, an}, 32'hE);

    checkDisplay("ch0 1234", SEG_1, SEG_2, SEG_3, SEG_4);
    checkOutput("ch0 led", {28'd0, led_ch}, 32'h1);
    applyStimulus(16'h0007, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    checkDisplay("ch0 0007", SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_7);
    applyStimulus(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    checkDisplay("ch0 0000", SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_0);
    applyStimulus(16'h0A00, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    checkDisplay("ch0 0A00", SEG_BLANK, SEG_DASH, SEG_0, SEG_0);
    checkOutput("dp idle", {31'd0, dp}, 32'h1);

    // Auto-advance: dwell was frozen at 0, so the first step lands one cycle later than the rest.
    applyStimulus(16'h0305, 16'h40A5, 16'h2222, 16'h3333, 1'b0);
    countToLedChange(n);
    checkOutput("dwell first cnt", n, 65);
    checkOutput("dwell led1", {28'd0, led_ch}, 32'h2);
    for (int i = 0; i < 3; i++) begin
      logic [3:0] ledExp;
      ledExp = (i == 0) ? 4'b0100 : (i == 1) ? 4'b1000 : 4'b0001;
      countToLedChange(n);
      checkOutput($sformatf("dwell cnt%0d", i), n, 64);
      checkOutput($sformatf("dwell led%0d", i + 2), {28'd0, led_ch}, {28'd0, ledExp});
    end

    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      btn_next = ((i / 3) % 2 == 0);
      @(negedge clk);
    end
    pressBtn(10, 12);
    checkOutput("bounce one advance", {28'd0, led_ch}, 32'h2);
    pressBtn(5, 15);
    checkOutput("short pulse no adv", {28'd0, led_ch}, 32'h2);
    hold = 1'b0;
    countToLedChange(n);
    checkOutput("dwell cleared by btn", n, 65);
    checkOutput("dwell after btn led", {28'd0, led_ch}, 32'h4);

    // Dwell terminal count falls 63 edges from here; button edge is timed to land on it.
    repeat (52) @(negedge clk);
    btn_next = 1'b1;
    repeat (11) @(negedge clk);
    checkOutput("coinc before", {28'd0, led_ch}, 32'h4);
    @(negedge clk);
    checkOutput("coinc single step", {28'd0, led_ch}, 32'h8);
    btn_next = 1'b0;
    countToLedChange(n);
    checkOutput("coinc next cnt", n, 64);
    checkOutput("coinc next led", {28'd0, led_ch}, 32'h1);

    hold = 1'b1;
    pressBtn(12, 12);
    checkOutput("btn with hold", {28'd0, led_ch}, 32'h2);
    checkDisplay("ch1 40A5", SEG_4, SEG_0, SEG_DASH, SEG_5);

    waitAn(4'b1110, "midframe");
    checkOutput("midframe units", {25'd0, sseg}, {25'd0, SEG_5});
    repeat (REFRESH_DIV) @(negedge clk);
    channel1 = 16'h9999;
    checkOutput("midframe tens", {25'd0, sseg}, {25'd0, SEG_DASH});
    repeat (REFRESH_DIV) @(negedge clk);
    checkOutput("midframe hund", {25'd0, sseg}, {25'd0, SEG_0});
    repeat (REFRESH_DIV) @(negedge clk);
    checkOutput("midframe thou", {25'd0, sseg}, {25'd0, SEG_4});
    waitAn(4'b1110, "newframe");
    checkOutput("newframe units", {25'd0, sseg}, {25'd0, SEG_9});

    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst an", {28'd0, an}, 32'hF);
    checkOutput("async rst sseg", {25'd0, sseg}, 32'h7F);
    checkOutput("async rst led", {28'd0, led_ch}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rerelease an", {28'd0, an}, 32'hE);
    checkOutput("rerelease units", {25'd0, sseg}, {25'd0, SEG_0});
    checkOutput("rerelease led", {28'd0, led_ch}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adc_channel_display.md
Name: adc_channel_display

Overview:
- Display stage directly downstream of the external ADC top, which supplies four 16-bit BCD channel words (4 digits each, 0000–4095).
- Auto-cycles or manually steps through the four channels.
- Scans the selected value onto the Basys3 4-digit multiplexed 7-segment display, with leading-zero blanking and a one-hot channel LED indicator.

Parameters:
- REFRESH_DIV, 100000, clk cycles per digit slot (1 ms at 100 MHz).
- DWELL_DIV, 200000000, clk cycles a channel is shown in auto mode (2 s).
- DEBOUNCE_CYC, 1000000, cycles btn_next must be stable before a level change is accepted (10 ms).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- channel0  in  16  BCD channel 0: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units
- channel1  in  16  BCD channel 1, same layout
- channel2  in  16  BCD channel 2, same layout
- channel3  in  16  BCD channel 3, same layout
- btn_next  in  1  raw pushbutton, asynchronous to clk, active-high
- hold  in  1  switch; 1 = freeze auto-advance
- sseg  out  7  segments {g,f,e,d,c,b,a}, active-low
- an  out  4  digit anodes, active-low; an[3] is the leftmost digit
- dp  out  1  decimal point, active-low; constant 1
- led_ch  out  4  one-hot index of the displayed channel

Behaviour:
- Reset (async, active-high): ch_idx=0, all counters 0, dig=0, snapshot=0, sseg=7'b1111111, an=4'b1111, dp=1, led_ch=4'b0001. All outputs are registered.
- btn_next path:
  - Two-flop synchronizer feeds the debouncer.
  - The debounced level changes only after DEBOUNCE_CYC consecutive cycles at the new synchronized level.
  - A rising edge of the debounced level produces a one-cycle next_pulse.
- Dwell counter:
  - Counts 0..DWELL_DIV-1 while hold=0.
  - At DWELL_DIV-1 it produces dwell_pulse and wraps to 0.
  - hold=1 freezes the count. Releasing hold resumes from the frozen value.
- Channel advance:
  - next_pulse OR dwell_pulse increments ch_idx modulo 4 (3 -> 0).
  - Both pulses in the same cycle advance by exactly one.
  - next_pulse clears the dwell counter to 0.
  - next_pulse advances even when hold=1.
  - led_ch = 1<<ch_idx, updated the cycle after ch_idx changes.
- Snapshot:
  - The selected channel word is latched into snapshot in the cycle ch_idx changes (new channel).
  - It is also latched at each frame start (dig wraps 3->0 on a refresh tick).
  - Input changes within a frame do not alter the displayed digits.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1; refresh_tick at the terminal count.
  - dig increments on each refresh_tick, 3 -> 0.
  - an = ~(4'b0001<<dig) and sseg, both registered, so there is 1 cycle latency from a dig change.
  - From the first cycle after reset release, an=4'b1110 showing the units digit.
- Decode, per nibble:
  - 0..9 uses standard patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Nibble >9 shows a dash, 0111111.
- Leading-zero blanking:
  - Thousands is blank (1111111) if 0.
  - Hundreds is blank if it and thousands are 0.
  - Tens is blank if it, hundreds and thousands are 0.
  - Units is never blanked.
  - A >9 nibble counts as non-zero.
- Reset asserted mid-frame or mid-debounce returns everything to reset values immediately; there is no partial state.

Test Plan (REFRESH_DIV=4, DWELL_DIV=64, DEBOUNCE_CYC=8):
- Reset, then release with channel0=16'h1234 and hold=1 -> an cycles 1110,1101,1011,0111 every 4 clks. Matching sseg is 0011001 (4), 0110000 (3), 0100100 (2), 1111001 (1). led_ch=0001.
- channel0=16'h0007 -> units shows 1111000 (7); tens, hundreds and thousands slots show 1111111. channel0=16'h0000 -> units shows 1000000.
- hold=0, all channels distinct -> led_ch steps 0001->0010->0100->1000->0001 every 64 clks.
- btn_next bounced high/low every 3 clks for 20 clks, then held high 10 clks -> exactly one advance, dwell counter reset. Pulses shorter than 8 clks -> no advance.
- btn_next edge timed to coincide with dwell terminal count -> ch_idx advances by 1, not 2.
- channel1=16'h40A5 selected -> tens digit shows 0111111 (dash); hundreds shows 1000000 because it is not blanked. Assert rst mid-frame -> an=1111, sseg=1111111, led_ch=0001 asynchronously.
